// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared types, widths and helpers for the divide sequencer
// Purpose: operation/state encodings, datapath width, counter width and the
//          magnitude helper used when latching signed operands.
// Ports:   none (package).
package div_sequencer_pkg;

   localparam int BIT_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(BIT_WIDTH);

   typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_t;
   typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_t;

   // Two's-complement magnitude for signed ops; 0x8000_0000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [BIT_WIDTH-1:0] magnitude(input logic [BIT_WIDTH-1:0] v,
                                                      input logic             is_signed);
      return (is_signed && v[BIT_WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response bundle between core and divide sequencer
// Purpose: groups the request handshake (req_valid/req_ready, op, in1, in2),
//          the response handshake (resp_valid/resp_ready, out) and busy.
// Ports:   master = core side, slave = sequencer side.
interface div_sequencer_if;
   import div_sequencer_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   div_op_t              op;
   logic [BIT_WIDTH-1:0] in1;
   logic [BIT_WIDTH-1:0] in2;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [BIT_WIDTH-1:0] out;
   logic                 busy;

   modport master (
      output req_valid, op, in1, in2, resp_ready,
      input  req_ready, resp_valid, out, busy
   );

   modport slave (
      input  req_valid, op, in1, in2, resp_ready,
      output req_ready, resp_valid, out, busy
   );

endinterface

// File: rtl/div_sequencer_step.sv
// rtl/div_sequencer_step.sv - one combinational radix-2 restoring division iteration
// Purpose: shift the next dividend bit into the partial remainder, trial-subtract
//          the divisor and restore on borrow.
// Ports:   rem_in (partial remainder), dvd_msb (next dividend bit), dvs (divisor),
//          rem_out (next partial remainder), q_bit (quotient bit produced).
module div_step
   import div_sequencer_pkg::*;
(
   input  logic [BIT_WIDTH-1:0] rem_in,
   input  logic                 dvd_msb,
   input  logic [BIT_WIDTH-1:0] dvs,
   output logic [BIT_WIDTH-1:0] rem_out,
   output logic                 q_bit
);

   // The trial runs one bit wider so the borrow lands in the MSB. The partial
   // remainder is always below the divisor, so the kept value fits BIT_WIDTH.
   logic [BIT_WIDTH:0] shifted;
   logic [BIT_WIDTH:0] diff;

   assign shifted = {rem_in, dvd_msb};
   assign diff    = shifted - {1'b0, dvs};
   assign q_bit   = ~diff[BIT_WIDTH];
   assign rem_out = q_bit ? diff[BIT_WIDTH-1:0] : shifted[BIT_WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer
// Purpose: radix-2 restoring divider, one quotient bit per cycle, with
//          single-cycle bypass for divide-by-zero and signed overflow.
// Ports:   CLK, nRST (sync active-low), kill (flush), bus (div_sequencer_if.slave).
// Config:  DIV_EARLY_OUT_EN - when defined, |in1| < |in2| also bypasses to DONE.
module div_sequencer
   import div_sequencer_pkg::*;
(
   input  logic           CLK,
   input  logic           nRST,
   input  logic           kill,
   div_sequencer_if.slave bus
);

   localparam logic [BIT_WIDTH-1:0] MIN_INT = {1'b1, {(BIT_WIDTH-1){1'b0}}};

   div_state_t           state;
   logic                 fix_phase;
   logic [DIV_CNT_W-1:0] cnt;
   div_op_t              op_r;
   logic [BIT_WIDTH-1:0] dvd;
   logic [BIT_WIDTH-1:0] dvs;
   logic [BIT_WIDTH-1:0] rem;
   logic [BIT_WIDTH-1:0] quo;
   logic [BIT_WIDTH-1:0] out_r;
   logic                 q_neg;
   logic                 r_neg;
   logic                 resp_valid_r;

   logic                 req_signed;
   logic                 req_rem;
   logic [BIT_WIDTH-1:0] mag1;
   logic [BIT_WIDTH-1:0] mag2;
   logic                 early_out;
   logic [BIT_WIDTH-1:0] step_rem;
   logic                 step_q;

   assign req_signed = (bus.op == DIV_DIV) || (bus.op == DIV_REM);
   assign req_rem    = (bus.op == DIV_REM) || (bus.op == DIV_REMU);
   assign mag1       = magnitude(bus.in1, req_signed);
   assign mag2       = magnitude(bus.in2, req_signed);

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (mag1 < mag2);
`else
   assign early_out = 1'b0;
`endif

   div_step u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[BIT_WIDTH-1]),
      .dvs     (dvs),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state        <= DIV_IDLE;
         fix_phase    <= 1'b0;
         cnt          <= '0;
         op_r         <= DIV_DIV;
         dvd          <= '0;
         dvs          <= '0;
         rem          <= '0;
         quo          <= '0;
         out_r        <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         resp_valid_r <= 1'b0;
      end else if (kill) begin
         state        <= DIV_IDLE;
         fix_phase    <= 1'b0;
         resp_valid_r <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (bus.req_valid) begin
                  op_r  <= bus.op;
                  q_neg <= req_signed & (bus.in1[BIT_WIDTH-1] ^ bus.in2[BIT_WIDTH-1]);
                  r_neg <= req_signed & bus.in1[BIT_WIDTH-1];
                  if (bus.in2 == '0) begin
                     out_r        <= req_rem ? bus.in1 : '1;
                     resp_valid_r <= 1'b1;
                     state        <= DIV_DONE;
                  end else if (req_signed && bus.in1 == MIN_INT && bus.in2 == '1) begin
                     out_r        <= req_rem ? '0 : MIN_INT;
                     resp_valid_r <= 1'b1;
                     state        <= DIV_DONE;
                  end else if (early_out) begin
                     out_r        <= req_rem ? bus.in1 : '0;
                     resp_valid_r <= 1'b1;
                     state        <= DIV_DONE;
                  end else begin
                     dvd   <= mag1;
                     dvs   <= mag2;
                     rem   <= '0;
                     quo   <= '0;
                     cnt   <= DIV_CNT_W'(BIT_WIDTH - 1);
                     state <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem <= step_rem;
               quo <= {quo[BIT_WIDTH-2:0], step_q};
               dvd <= {dvd[BIT_WIDTH-2:0], 1'b0};
               cnt <= cnt - 1'b1;
               if (cnt == '0)
                  state <= DIV_FIX;
            end
            DIV_FIX: begin
               // Two beats: sign-correct in place, then select into out, so the
               // negators and the result mux are never on the same path.
               if (!fix_phase) begin
                  if (q_neg) quo <= -quo;
                  if (r_neg) rem <= -rem;
                  fix_phase <= 1'b1;
               end else begin
                  out_r        <= (op_r == DIV_REM || op_r == DIV_REMU) ? rem : quo;
                  fix_phase    <= 1'b0;
                  resp_valid_r <= 1'b1;
                  state        <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  state        <= DIV_IDLE;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == DIV_IDLE) && nRST;
   assign bus.busy       = (state != DIV_IDLE);
   assign bus.resp_valid = resp_valid_r;
   assign bus.out        = out_r;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;
   import div_sequencer_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   logic kill;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] exp_out;
   int          exp_lat;
   logic        resp_allowed;

   div_sequencer_if bus();

   div_sequencer dut (
      .CLK  (CLK),
      .nRST (nRST),
      .kill (kill),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Architectural result of an RV32M divide/remainder.
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      logic is_rem;
      int   sa;
      int   sb;
      sgn    = (o == 2'd0) || (o == 2'd2);
      is_rem = (o == 2'd2) || (o == 2'd3);
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      if (sgn) begin
         sa = a;
         sb = b;
         return is_rem ? 32'(sa % sb) : 32'(sa / sb);
      end
      return is_rem ? (a % b) : (a / b);
   endfunction

   // Edges from acceptance to the first edge with resp_valid high.
   function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic        sgn;
      logic [31:0] ma;
      logic [31:0] mb;
      sgn = (o == 2'd0) || (o == 2'd2);
      ma  = (sgn && a[31]) ? 32'd0 - a : a;
      mb  = (sgn && b[31]) ? 32'd0 - b : b;
      if (b == 32'd0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`else
      if (ma < mb) return 34;
`endif
      return 34;
   endfunction

   // Advance one cycle and compare outputs at the falling edge.
   task automatic tick();
      @(negedge CLK);
      if (nRST && bus.resp_valid) begin
         checks++;
         if (!resp_allowed) begin
            errors++;
            $display("FAIL unexpected_resp: resp_valid=1 out=%h", bus.out);
         end else if (bus.out !== exp_out) begin
            errors++;
            $display("FAIL out: got %h expected %h", bus.out, exp_out);
         end
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
      int n;
      exp_out       = model(o, a, b);
      exp_lat       = latency(o, a, b);
      resp_allowed  = 1'b1;
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.op        = div_op_t'(o);
      bus.in1       = a;
      bus.in2       = b;
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.resp_valid && n < 200);
      check("latency", 32'(n), 32'(exp_lat));
      for (int i = 0; i < hold; i++) tick();
      check("resp_held", 32'(bus.resp_valid), 32'd1);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      check("retire_valid", 32'(bus.resp_valid), 32'd0);
      check("retire_busy", 32'(bus.busy), 32'd0);
      resp_allowed = 1'b0;
   endtask

   task automatic check_zeroed(input string tag);
      check({tag, "_out"}, bus.out, 32'd0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          kind;

      nRST           = 1'b0;
      kill           = 1'b0;
      resp_allowed   = 1'b0;
      exp_out        = '0;
      exp_lat        = 0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      bus.op         = DIV_DIV;
      bus.in1        = '0;
      bus.in2        = '0;
      repeat (3) tick();
      check_zeroed("reset");
      nRST = 1'b1;
      tick();

      // Hand-computed pins on the reference model.
      check("model_divu", model(2'd1, 32'd100, 32'd7), 32'd14);
      check("model_remu", model(2'd3, 32'd100, 32'd7), 32'd2);
      check("model_div_neg", model(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_rem_neg", model(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("model_div_ovf", model(2'd0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      check("model_divu_zero", model(2'd1, 32'd5, 32'd0), 32'hFFFF_FFFF);

      // Directed cases.
      run_op(2'd1, 32'd100, 32'd7, 5);
      run_op(2'd3, 32'd100, 32'd7, 0);
      run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2);
      run_op(2'd1, 32'd5, 32'd0, 0);
      run_op(2'd3, 32'd5, 32'd0, 0);
      run_op(2'd1, 32'd3, 32'd9, 0);
      run_op(2'd2, 32'hFFFF_FFFD, 32'd9, 0);
      run_op(2'd0, 32'h8000_0000, 32'd1, 0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0);

      // kill in the middle of CALC abandons the operation.
      bus.req_valid = 1'b1;
      bus.op        = DIV_DIVU;
      bus.in1       = 32'd1000;
      bus.in2       = 32'd3;
      tick();
      bus.req_valid = 1'b0;
      repeat (10) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill_busy", 32'(bus.busy), 32'd0);
      check("kill_resp_valid", 32'(bus.resp_valid), 32'd0);
      repeat (40) tick();
      run_op(2'd1, 32'd1000, 32'd3, 0);

      // kill together with a request in IDLE blocks acceptance.
      bus.req_valid = 1'b1;
      kill          = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      kill          = 1'b0;
      check("kill_idle_busy", 32'(bus.busy), 32'd0);

      // Reset in the middle of CALC clears every output.
      bus.req_valid = 1'b1;
      bus.op        = DIV_DIV;
      bus.in1       = 32'd77;
      bus.in2       = 32'd5;
      tick();
      bus.req_valid = 1'b0;
      repeat (5) tick();
      nRST = 1'b0;
      tick();
      check_zeroed("reset_calc");
      nRST = 1'b1;
      tick();
      check("after_reset_ready", 32'(bus.req_ready), 32'd1);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         o    = 2'($urandom_range(0, 3));
         kind = $urandom_range(0, 9);
         case (kind)
            0: begin a = $urandom; b = 32'd0; end
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 20); end
            3: begin a = $urandom_range(0, 100); b = $urandom | 32'h0001_0000; end
            4: begin a = $urandom; b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         run_op(o, a, b, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
